exe_stage: RTL and testbench

Execute/write-back stage of the mini-core, sitting directly downstream of the load-stage pipeline register. It consumes that register's outputs: operand pair, destination address, ALU opcode, store flag, mul/add select and halt. It produces register-file and data-memory write ports. It also drives `freeze` back to the load stage while a multi-cycle multiply is in flight.

---
 rtl/exe_pkg.sv | 20 ++
 rtl/seq_mul.sv | 50 +++++
 rtl/exe_stage.sv | 154 +++++++++++++++
 tb/tb_exe_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the mini-core execute/write-back stage.
//   DEF_DATA_W / DEF_ADR_W : default operand and address widths
//   OP_ADD/OP_SUB/OP_AND/OP_PASS : 2-bit ALU opcodes
//   exe_state_e : execute-stage state (IDLE, MUL)
package exe_pkg;

  localparam int unsigned DEF_DATA_W = 6;
  localparam int unsigned DEF_ADR_W  = 6;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } exe_state_e;

endpackage

// File: rtl/seq_mul.sv
// seq_mul: shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands a/b, clear accumulator and counter
//   run      : advance one iteration this cycle
//   a, b     : multiplicand, multiplier
//   done     : current iteration is the last one (counter == DATA_W-1)
//   product  : accumulator including this cycle's partial product; on the
//              done cycle it is the final product (low DATA_W bits)
module seq_mul #(
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (run) begin
      // Multiplicand walks left, multiplier walks right: bit 0 selects.
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= product;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute/write-back stage of the mini-core.
// Optional multi-cycle multiplier enabled by defining EXE_MUL_EN.
//   clk, rst            : clock, synchronous active-high reset
//   halted              : bubble / halt marker from the load stage
//   write_adr           : destination register, or memory address for stores
//   alu_inst            : 00 add, 01 sub, 10 and, 11 pass data_1
//   data_1, data_2      : operands
//   data_mem_write      : instruction is a store (wins over multiply)
//   mul_or_add_ld       : multiply (only with EXE_MUL_EN)
//   freeze              : combinational hold request to the load stage
//   rf_we/rf_waddr/rf_wdata  : registered register-file write port
//   dm_we/dm_addr/dm_wdata   : registered data-memory write port
//   halted_out          : sticky halted flag, cleared only by rst
module exe_stage
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADR_W  = DEF_ADR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted,
  input  logic [ADR_W-1:0]  write_adr,
  input  logic [1:0]        alu_inst,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic              data_mem_write,
  input  logic              mul_or_add_ld,
  output logic              freeze,
  output logic              rf_we,
  output logic [ADR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              dm_we,
  output logic [ADR_W-1:0]  dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              halted_out
);

  logic              rf_we_d, dm_we_d, halted_out_d;
  logic [ADR_W-1:0]  rf_waddr_d, dm_addr_d;
  logic [DATA_W-1:0] rf_wdata_d, dm_wdata_d;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    unique case (alu_inst)
      OP_ADD:  alu_res = data_1 + data_2;
      OP_SUB:  alu_res = data_1 - data_2;
      OP_AND:  alu_res = data_1 & data_2;
      OP_PASS: alu_res = data_1;
      default: alu_res = '0;
    endcase
  end

`ifdef EXE_MUL_EN
  exe_state_e        state_q, state_d;
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [ADR_W-1:0]  mul_adr_q;

  seq_mul #(
    .DATA_W(DATA_W)
  ) u_seq_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .run    (state_q == MUL),
    .a      (data_1),
    .b      (data_2),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mul_adr_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) mul_adr_q <= write_adr;
    end
  end
`else
  logic unused_mul_sel;
  assign unused_mul_sel = mul_or_add_ld;
  assign freeze         = 1'b0;
`endif

  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = '0;
    rf_wdata_d   = '0;
    dm_we_d      = 1'b0;
    dm_addr_d    = '0;
    dm_wdata_d   = '0;
    halted_out_d = halted_out;
`ifdef EXE_MUL_EN
    state_d   = state_q;
    mul_start = 1'b0;
    freeze    = 1'b0;
    if (state_q == MUL) begin
      // Release the load stage on the last iteration so the next
      // instruction arrives exactly as we return to IDLE.
      freeze = !mul_done;
      if (mul_done) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = mul_adr_q;
        rf_wdata_d = mul_product;
        state_d    = IDLE;
      end
    end else
`endif
    if (halted_out) begin
      // Core halted: everything ignored until reset.
    end else if (halted) begin
      halted_out_d = 1'b1;
    end else if (data_mem_write) begin
      dm_we_d    = 1'b1;
      dm_addr_d  = write_adr;
      dm_wdata_d = data_1;
`ifdef EXE_MUL_EN
    end else if (mul_or_add_ld) begin
      mul_start = 1'b1;
      freeze    = 1'b1;
      state_d   = MUL;
`endif
    end else begin
      rf_we_d    = 1'b1;
      rf_waddr_d = write_adr;
      rf_wdata_d = alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      halted_out <= 1'b0;
    end else begin
      rf_we      <= rf_we_d;
      rf_waddr   <= rf_waddr_d;
      rf_wdata   <= rf_wdata_d;
      dm_we      <= dm_we_d;
      dm_addr    <= dm_addr_d;
      dm_wdata   <= dm_wdata_d;
      halted_out <= halted_out_d;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage.
// Multiply scenarios run only when EXE_MUL_EN is defined; otherwise the
// multiply-ignored scenario runs instead.
module tb_exe_stage;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned ADR_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              halted;
  logic [ADR_W-1:0]  write_adr;
  logic [1:0]        alu_inst;
  logic [DATA_W-1:0] data_1, data_2;
  logic              data_mem_write;
  logic              mul_or_add_ld;
  logic              freeze;
  logic              rf_we, dm_we, halted_out;
  logic [ADR_W-1:0]  rf_waddr, dm_addr;
  logic [DATA_W-1:0] rf_wdata, dm_wdata;

  int errors = 0;
  int checks = 0;

  exe_stage #(
    .DATA_W(DATA_W),
    .ADR_W (ADR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .halted        (halted),
    .write_adr     (write_adr),
    .alu_inst      (alu_inst),
    .data_1        (data_1),
    .data_2        (data_2),
    .data_mem_write(data_mem_write),
    .mul_or_add_ld (mul_or_add_ld),
    .freeze        (freeze),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .halted_out    (halted_out)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic [ADR_W-1:0] adr, input logic [1:0] op,
                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input logic st, input logic mul);
    halted         = h;
    write_adr      = adr;
    alu_inst       = op;
    data_1         = d1;
    data_2         = d2;
    data_mem_write = st;
    mul_or_add_ld  = mul;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, halted_out, freeze} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rf_we=%b rf_waddr=%0d rf_wdata=%0d dm_we=%b dm_addr=%0d dm_wdata=%0d halted_out=%b freeze=%b required all 0",
               rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, halted_out, freeze);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(1'b0, 6'd3, 2'b00, 6'd30, 6'd40, 1'b0, 1'b0);
    checks++;
    if (freeze !== 1'b0) begin
      errors++;
      $display("FAIL add_freeze: got %b required 0", freeze);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, dm_we} !== {1'b1, 6'd3, 6'd6, 1'b0}) begin
      errors++;
      $display("FAIL add_write: got rf_we=%b rf_waddr=%0d rf_wdata=%0d dm_we=%b required 1 3 6 0",
               rf_we, rf_waddr, rf_wdata, dm_we);
    end
  endtask

  task automatic test_sub_and_pass_store();
    drive(1'b0, 6'd1, 2'b01, 6'd5, 6'd9, 1'b0, 1'b0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd1, 6'd60}) begin
      errors++;
      $display("FAIL sub_wrap: got rf_we=%b rf_waddr=%0d rf_wdata=%0d required 1 1 60",
               rf_we, rf_waddr, rf_wdata);
    end
    drive(1'b0, 6'd12, 2'b00, 6'd17, 6'd5, 1'b1, 1'b1);
    checks++;
    if (freeze !== 1'b0) begin
      errors++;
      $display("FAIL store_freeze: got %b required 0", freeze);
    end
    tick();
    checks++;
    if ({dm_we, dm_addr, dm_wdata, rf_we} !== {1'b1, 6'd12, 6'd17, 1'b0}) begin
      errors++;
      $display("FAIL store_write: got dm_we=%b dm_addr=%0d dm_wdata=%0d rf_we=%b required 1 12 17 0",
               dm_we, dm_addr, dm_wdata, rf_we);
    end
    drive(1'b0, 6'd9, 2'b10, 6'b101101, 6'b110011, 1'b0, 1'b0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, dm_we} !== {1'b1, 6'd9, 6'b100001, 1'b0}) begin
      errors++;
      $display("FAIL and_write: got rf_we=%b rf_waddr=%0d rf_wdata=%0d dm_we=%b required 1 9 33 0",
               rf_we, rf_waddr, rf_wdata, dm_we);
    end
    drive(1'b0, 6'd63, 2'b11, 6'd42, 6'd7, 1'b0, 1'b0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd63, 6'd42}) begin
      errors++;
      $display("FAIL pass_write: got rf_we=%b rf_waddr=%0d rf_wdata=%0d required 1 63 42",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

`ifdef EXE_MUL_EN
  // Present a multiply, hold it while freeze is high (as the load stage
  // would), then check the write-back one cycle after freeze drops.
  task automatic run_mul(input logic [ADR_W-1:0] adr, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp_p,
                         input string name);
    int n_freeze = 0;
    int early_we = 0;
    drive(1'b0, adr, 2'b01, a, b, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (!freeze) break;
      n_freeze++;
      tick();
      if (rf_we !== 1'b0) early_we++;
    end
    checks++;
    if (n_freeze != DATA_W) begin
      errors++;
      $display("FAIL %s_freeze_cycles: got %0d required %0d", name, n_freeze, DATA_W);
    end
    checks++;
    if (early_we != 0) begin
      errors++;
      $display("FAIL %s_early_we: got %0d write pulses during freeze required 0", name, early_we);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, dm_we} !== {1'b1, adr, exp_p, 1'b0}) begin
      errors++;
      $display("FAIL %s_result: got rf_we=%b rf_waddr=%0d rf_wdata=%0d dm_we=%b required 1 %0d %0d 0",
               name, rf_we, rf_waddr, rf_wdata, dm_we, adr, exp_p);
    end
  endtask

  task automatic test_back_to_back_mul();
    run_mul(6'd7, 6'd9, 6'd9, 6'd17, "mul9x9");
    run_mul(6'd2, 6'd7, 6'd9, 6'd63, "mul7x9");
    // A store right after: the product pulse must not repeat.
    drive(1'b0, 6'd4, 2'b00, 6'd1, 6'd1, 1'b1, 1'b0);
    tick();
    checks++;
    if ({rf_we, dm_we} !== 2'b01) begin
      errors++;
      $display("FAIL mul_pulse_once: got rf_we=%b dm_we=%b required 0 1", rf_we, dm_we);
    end
  endtask

  task automatic test_mul_reset();
    int late_we = 0;
    drive(1'b0, 6'd4, 2'b00, 6'd5, 6'd5, 1'b0, 1'b1);
    // Edge after dispatch gives counter 0; four edges reach counter 3.
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    drive(1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, halted_out, freeze} !== '0) begin
      errors++;
      $display("FAIL mul_reset_outputs: got rf_we=%b rf_wdata=%0d dm_we=%b halted_out=%b freeze=%b required all 0",
               rf_we, rf_wdata, dm_we, halted_out, freeze);
    end
    rst = 1'b0;
    drive(1'b0, 6'd8, 2'b00, 6'd3, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we !== 1'b0) late_we++;
    end
    checks++;
    if (late_we != 0) begin
      errors++;
      $display("FAIL mul_reset_no_write: got %0d rf_we pulses required 0", late_we);
    end
  endtask
`else
  task automatic test_mul_ignored();
    drive(1'b0, 6'd5, 2'b00, 6'd3, 6'd4, 1'b0, 1'b1);
    checks++;
    if (freeze !== 1'b0) begin
      errors++;
      $display("FAIL nomul_freeze: got %b required 0", freeze);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd5, 6'd7}) begin
      errors++;
      $display("FAIL nomul_add: got rf_we=%b rf_waddr=%0d rf_wdata=%0d required 1 5 7",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask
`endif

  task automatic test_halt();
    drive(1'b1, 6'd2, 2'b00, 6'd1, 6'd2, 1'b0, 1'b0);
    tick();
    checks++;
    if ({halted_out, rf_we, dm_we} !== 3'b100) begin
      errors++;
      $display("FAIL halt_set: got halted_out=%b rf_we=%b dm_we=%b required 1 0 0",
               halted_out, rf_we, dm_we);
    end
    drive(1'b0, 6'd2, 2'b00, 6'd1, 6'd2, 1'b0, 1'b0);
    tick();
    checks++;
    if ({halted_out, rf_we, dm_we} !== 3'b100) begin
      errors++;
      $display("FAIL halt_add_blocked: got halted_out=%b rf_we=%b dm_we=%b required 1 0 0",
               halted_out, rf_we, dm_we);
    end
    drive(1'b0, 6'd3, 2'b00, 6'd1, 6'd2, 1'b1, 1'b1);
    checks++;
    if (freeze !== 1'b0) begin
      errors++;
      $display("FAIL halt_freeze: got %b required 0", freeze);
    end
    tick();
    checks++;
    if ({halted_out, rf_we, dm_we} !== 3'b100) begin
      errors++;
      $display("FAIL halt_store_blocked: got halted_out=%b rf_we=%b dm_we=%b required 1 0 0",
               halted_out, rf_we, dm_we);
    end
    rst = 1'b1;
    drive(1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (halted_out !== 1'b0) begin
      errors++;
      $display("FAIL halt_cleared_by_rst: got %b required 0", halted_out);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and_pass_store();
`ifdef EXE_MUL_EN
    test_back_to_back_mul();
    test_mul_reset();
`else
    test_mul_ignored();
`endif
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
